// File: rtl/serial_number_display.sv
// serial_number_display: latches the six-character ASCII serial from the
// generator, reveals it left to right on a multiplexed common-anode
// seven-segment display, then holds it (blinking while detonating).
module serial_number_display #(
  parameter int SCAN_DIV   = 50000,
  parameter int REVEAL_DIV = 25000000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  current_state,
  input  logic [47:0] serial_number,
  input  logic        serial_done,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [5:0]  an_n,
  output logic        revealed
);

  localparam logic [2:0] GS_IDLE       = 3'd0;
  localparam logic [2:0] GS_DETONATING = 3'd3;

  localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int REV_W   = $clog2(REVEAL_DIV + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [REV_W-1:0]   REV_LAST   = REV_W'(REVEAL_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    BLANK  = 2'd0,
    REVEAL = 2'd1,
    SHOW   = 2'd2
  } disp_state_t;

  disp_state_t        state, state_nxt;
  logic [2:0]         rev_cnt;
  logic [REV_W-1:0]   rev_div;
  logic [47:0]        shadow;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         slot;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               is_idle, capture, rev_tick, slot_on, dp_on;
  logic [7:0]         cur_char;

  // Active-high {g,f,e,d,c,b,a} glyph for one ASCII code; unknown codes show '-'.
  function automatic logic [6:0] font(input logic [7:0] c);
    logic [6:0] f;
    case (c)
      "0": f = 7'h3F;  "1": f = 7'h06;  "2": f = 7'h5B;  "3": f = 7'h4F;
      "4": f = 7'h66;  "5": f = 7'h6D;  "6": f = 7'h7D;  "7": f = 7'h07;
      "8": f = 7'h7F;  "9": f = 7'h6F;
      "A": f = 7'h77;  "B": f = 7'h7C;  "C": f = 7'h39;  "D": f = 7'h5E;
      "E": f = 7'h79;  "F": f = 7'h71;  "G": f = 7'h3D;  "H": f = 7'h76;
      "I": f = 7'h30;  "J": f = 7'h1E;  "K": f = 7'h75;  "L": f = 7'h38;
      "M": f = 7'h37;  "N": f = 7'h54;
      "P": f = 7'h73;  "Q": f = 7'h67;  "R": f = 7'h50;  "S": f = 7'h6D;
      "T": f = 7'h78;  "U": f = 7'h3E;  "V": f = 7'h1C;  "W": f = 7'h2A;
      "X": f = 7'h49;  "Z": f = 7'h5B;
      default: f = 7'h40;
    endcase
    return f;
  endfunction

  assign is_idle  = (current_state == GS_IDLE);
  assign capture  = (state == BLANK) && serial_done && !is_idle;
  assign rev_tick = (state == REVEAL) && (rev_div == REV_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BLANK;
    else      state <= state_nxt;
  end

  // FSM next state: IDLE forces BLANK ahead of any capture.
  always_comb begin
    state_nxt = state;
    if (is_idle) begin
      state_nxt = BLANK;
    end else begin
      case (state)
        BLANK:   if (serial_done) state_nxt = REVEAL;
        REVEAL:  if (rev_tick && (rev_cnt == 3'd6)) state_nxt = SHOW;
        SHOW:    state_nxt = SHOW;
        default: state_nxt = BLANK;
      endcase
    end
  end

  // Shadow capture, reveal divider and count of characters made visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= {6{8'h30}};
      rev_cnt <= 3'd0;
      rev_div <= '0;
    end else if (is_idle) begin
      rev_cnt <= 3'd0;
      rev_div <= '0;
    end else if (capture) begin
      shadow  <= serial_number;
      rev_cnt <= 3'd1;
      rev_div <= '0;
    end else if (state == REVEAL) begin
      if (rev_tick) begin
        rev_div <= '0;
        if (rev_cnt < 3'd6) rev_cnt <= rev_cnt + 3'd1;
      end else begin
        rev_div <= rev_div + 1'b1;
      end
    end
  end

  // Free-running digit scan, independent of game and display state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      slot     <= 3'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink phase runs only while detonating; any other state parks it at 0,
  // so every entry into DETONATING starts from a cleared counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (current_state != GS_DETONATING) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Character under the current scan slot (slot 0 is the leftmost byte).
  always_comb begin
    cur_char = shadow[47:40];
    case (slot)
      3'd1:    cur_char = shadow[39:32];
      3'd2:    cur_char = shadow[31:24];
      3'd3:    cur_char = shadow[23:16];
      3'd4:    cur_char = shadow[15:8];
      3'd5:    cur_char = shadow[7:0];
      default: cur_char = shadow[47:40];
    endcase
  end

  assign slot_on = !blink_phase &&
                   ((state == SHOW) || ((state == REVEAL) && (slot < rev_cnt)));
  assign dp_on   = slot_on && (state == SHOW) && (slot == 3'd5) && shadow[0];

  // Output stage: registered segment, anode and status drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
      an_n     <= 6'h3F;
      revealed <= 1'b0;
    end else begin
      seg_n    <= slot_on ? ~font(cur_char) : 7'h7F;
      an_n     <= slot_on ? ~(6'b000001 << slot) : 6'h3F;
      dp_n     <= ~dp_on;
      revealed <= (state == SHOW);
    end
  end

endmodule

// File: tb/tb_serial_number_display.sv
// Bench for serial_number_display: elapsed-time reference model compared
// every cycle, plus literal expectations for the key display scenarios.
module tb_serial_number_display;

  localparam int SCAN_DIV   = 4;
  localparam int REVEAL_DIV = 16;
  localparam int BLINK_DIV  = 8;

  logic        clk, rst;
  logic [2:0]  current_state;
  logic [47:0] serial_number;
  logic        serial_done;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [5:0]  an_n;
  logic        revealed;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int cap_cyc  = 0;
  bit chk_en   = 0;

  logic [6:0] font_tab [256];

  // Reference model state: elapsed edges since reset, capture and detonation entry.
  int          m_edges, m_k, m_d;
  bit          m_active;
  logic [47:0] m_shadow;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic [5:0]  exp_an  = 6'h3F;
  logic        exp_rev = 1'b0;

  serial_number_display #(
    .SCAN_DIV  (SCAN_DIV),
    .REVEAL_DIV(REVEAL_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .current_state(current_state),
    .serial_number(serial_number),
    .serial_done  (serial_done),
    .seg_n        (seg_n),
    .dp_n         (dp_n),
    .an_n         (an_n),
    .revealed     (revealed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] s2v(input string s);
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[8*(5-i) +: 8] = s[i];
    return v;
  endfunction

  // Reference model: outputs after an edge follow the situation before it.
  always @(posedge clk or negedge rst) begin
    int s, rcnt, phase;
    bit showing, on;
    logic [7:0] ch;
    if (!rst) begin
      m_edges = 0; m_k = 0; m_d = 0; m_active = 0;
      m_shadow = {6{8'h30}};
      exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 6'h3F; exp_rev = 1'b0;
    end else begin
      s       = (m_edges / SCAN_DIV) % 6;
      showing = m_active && (m_k >= 6 * REVEAL_DIV);
      if (!m_active)   rcnt = 0;
      else if (showing) rcnt = 6;
      else             rcnt = 1 + m_k / REVEAL_DIV;
      phase   = (m_d / BLINK_DIV) % 2;
      on      = m_active && (s < rcnt) && (phase == 0);
      ch      = m_shadow[8*(5-s) +: 8];
      exp_an  = on ? ~(6'b000001 << s) : 6'h3F;
      exp_seg = on ? ~font_tab[ch] : 7'h7F;
      exp_dp  = !(on && showing && (s == 5) && m_shadow[0]);
      exp_rev = showing;
      m_edges++;
      if (current_state == 3'd3) m_d++; else m_d = 0;
      if (current_state == 3'd0) m_active = 0;
      else if (!m_active && serial_done) begin
        m_active = 1; m_k = 0; m_shadow = serial_number;
      end else if (m_active && m_k < 6 * REVEAL_DIV) m_k++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("an_n", 48'(an_n), 48'(exp_an));
      chk("dp_n", 48'(dp_n), 48'(exp_dp));
      chk("revealed", 48'(revealed), 48'(exp_rev));
      if (exp_an != 6'h3F) chk("seg_n", 48'(seg_n), 48'(exp_seg));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [5:0] v, input int lim, input string name);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (an_n !== v && i < lim);
    if (an_n !== v) chk(name, 48'(an_n), 48'(v));
  endtask

  task automatic wait_rev(input int lim);
    int i;
    i = 0;
    do begin @(negedge clk); i++; end while (revealed !== 1'b1 && i < lim);
    if (revealed !== 1'b1) chk("revealed_timeout", 48'(revealed), 48'd1);
  endtask

  task automatic only_char0(input string name);
    for (int i = 0; i <= REVEAL_DIV; i++) begin
      @(negedge clk);
      chk(name, 48'((an_n == 6'h3F) || (an_n == 6'h3E)), 48'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    string digs, lets;
    logic [6:0] dcode [10];
    logic [6:0] lcode [24];
    logic [7:0] c;
    digs  = "0123456789";
    lets  = "ABCDEFGHIJKLMNPQRSTUVWXZ";
    dcode = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    lcode = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h30, 7'h1E,
              7'h75, 7'h38, 7'h37, 7'h54, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E,
              7'h1C, 7'h2A, 7'h49, 7'h5B};
    for (int i = 0; i < 256; i++) font_tab[i] = 7'h40;
    for (int i = 0; i < 10; i++) begin c = digs[i]; font_tab[c] = dcode[i]; end
    for (int i = 0; i < 24; i++) begin c = lets[i]; font_tab[c] = lcode[i]; end

    rst = 1'b1; current_state = 3'd0; serial_done = 1'b1;
    serial_number = s2v("AB3Z57");
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    cycles(3);
    rst = 1'b1;

    // IDLE with serial_done high: nothing is captured or shown.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("idle_an", 48'(an_n), 48'h3F);
      chk("idle_revealed", 48'(revealed), 48'd0);
    end

    // Capture and reveal "AB3Z57".
    current_state = 3'd1;
    cap_cyc = cyc + 1;
    only_char0("early_only_an0");
    wait_an(6'h3E, 40, "char0_timeout");
    chk("char0_seg_A", 48'(seg_n), 48'h08);
    wait_an(6'h37, 120, "slot3_timeout");
    chk("slot3_seg_Z", 48'(seg_n), 48'h24);
    wait_rev(200);
    chk("reveal_latency", 48'(cyc - cap_cyc), 48'd97);

    // Blink while detonating: 8 scanned cycles, 8 blank cycles.
    current_state = 3'd3;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("blink_blank", 48'(an_n == 6'h3F), 48'(((i / 8) % 2) == 1));
    end
    current_state = 3'd2;
    cycles(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("steady_an", 48'(an_n != 6'h3F), 48'd1);
    end

    // Abort at rev_cnt=3, then reveal restarts with a new serial.
    current_state = 3'd0;
    cycles(3);
    serial_number = s2v("HELP12");
    current_state = 3'd1;
    cycles(41);
    current_state = 3'd0;
    cycles(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_an", 48'(an_n), 48'h3F);
      chk("abort_revealed", 48'(revealed), 48'd0);
    end
    serial_number = s2v("OOOOO7");
    current_state = 3'd1;
    only_char0("restart_only_an0");
    wait_an(6'h3E, 40, "restart_char0_timeout");
    chk("dash_slot0_seg", 48'(seg_n), 48'h3F);
    wait_an(6'h3B, 120, "slot2_timeout");
    chk("dash_slot2_seg", 48'(seg_n), 48'h3F);
    wait_rev(200);
    wait_an(6'h1F, 40, "slot5_timeout");
    chk("slot5_seg_7", 48'(seg_n), 48'h78);
    chk("slot5_dp_odd", 48'(dp_n), 48'd0);

    // Even last digit: decimal point never lit.
    current_state = 3'd0;
    cycles(2);
    serial_number = s2v("A00002");
    current_state = 3'd1;
    wait_rev(200);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      chk("even_dp", 48'(dp_n), 48'd1);
    end
    wait_an(6'h1F, 40, "even_slot5_timeout");
    chk("slot5_seg_2", 48'(seg_n), 48'h24);

    // Asynchronous reset between clock edges during SHOW.
    #3 rst = 1'b0;
    #1;
    chk("async_an", 48'(an_n), 48'h3F);
    chk("async_seg", 48'(seg_n), 48'h7F);
    chk("async_dp", 48'(dp_n), 48'd1);
    chk("async_revealed", 48'(revealed), 48'd0);
    cycles(3);
    rst = 1'b1;
    cycles(30);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_number_display.md
# serial_number_display

Drives a six-digit multiplexed common-anode seven-segment display with the bomb's serial number. It consumes the 48-bit ASCII serial and its completion flag from the serial-number generator, latches them, and reveals the characters left to right. It then holds the full serial on the display, blinking during detonation. The block sits directly downstream of the generator and directly upstream of the board's segment and anode pins.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; minimum 2.
- REVEAL_DIV, 25000000: clk cycles between successive character reveals.
- BLINK_DIV, 12500000: clk cycles per blink half-period while DETONATING.
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- current_state  in  3  game state:
  - IDLE=0, ACTIVATING=1, ACTIVATED=2, DETONATING=3, MISSION_FAILED=4, MISSION_SUCCESSED=5.
- serial_number  in  48  six ASCII characters; char0 = [47:40] (leftmost) … char5 = [7:0].
- serial_done  in  1  serial_number valid and stable while high.
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- an_n  out  6  active-low digit enables; an_n[i] selects char i.
- revealed  out  1  high while all six characters are shown.

## Operation
- Capture: in BLANK, when serial_done=1 and current_state≠IDLE:
  - copy serial_number into the 48-bit shadow register;
  - set rev_cnt=1 and enter REVEAL.
- FSM states BLANK, REVEAL, SHOW:
  - BLANK: all anodes off.
  - REVEAL: chars 0..rev_cnt−1 are driven; the other slots are blanked (anode off).
    - A reveal counter ticks every REVEAL_DIV cycles.
    - On a tick with rev_cnt<6, rev_cnt increments.
    - On a tick with rev_cnt=6, go to SHOW.
  - SHOW: all six characters shown; revealed=1.
- current_state=IDLE in any state forces BLANK next cycle:
  - rev_cnt=0, reveal counter and blink state cleared;
  - IDLE has priority over capture in the same cycle;
  - the shadow register is kept and overwritten at the next capture.
- Scan: free-running slot index 0..5.
  - Advances every SCAN_DIV cycles and wraps 5→0.
  - Runs in all states from reset.
- Font, active-high hex of {g..a}, inverted onto seg_n:
  - Digits: '0'=3F '1'=06 '2'=5B '3'=4F '4'=66 '5'=6D '6'=7D '7'=07 '8'=7F '9'=6F.
  - Letters A–N: A=77 B=7C C=39 D=5E E=79 F=71 G=3D H=76 I=30 J=1E K=75 L=38 M=37 N=54.
  - Letters P–Z: P=73 Q=67 R=50 S=6D T=78 U=3E V=1C W=2A X=49 Z=5B.
  - Any other code, including 'O', 'Y' and lowercase, displays 40 ('-').
- Decimal point: dp_n=0 only while slot 5 is driven in SHOW and shadow[0]=1 (last digit odd); otherwise 1.
- Blink, DETONATING only:
  - blink_phase toggles every BLINK_DIV cycles.
  - While blink_phase=1, all anodes are off.
  - On entry to DETONATING, blink_phase=0 and the blink counter is cleared.
  - In every other state, blink_phase is held at 0.
- MISSION_FAILED and MISSION_SUCCESSED: steady display of whatever the FSM currently shows; the reveal continues if unfinished.

## Timing
- Reset values:
  - seg_n=7'h7F, dp_n=1, an_n=6'h3F, revealed=0;
  - FSM=BLANK, rev_cnt=0, slot=0, all counters 0, blink_phase=0, shadow=48'h303030303030.
- All outputs are registered. seg_n, an_n and dp_n reflect slot, FSM, rev_cnt and blink state one cycle after those change.
- Capture latency:
  - cycle of capture: FSM→REVEAL;
  - +1: char0 eligible, appearing when slot 0 is next driven.
- Full reveal: 6×REVEAL_DIV cycles after capture, then revealed=1 on the cycle after the 6th tick.
- Blanking: exactly one anode is low at any time, except when blanked (BLANK, unrevealed slot, blink_phase=1), where none are low.
- serial_done falling after capture has no effect; a new capture requires passing through BLANK.
- Asynchronous reset mid-reveal or mid-blink returns immediately to the reset values.

## Test plan
Bench parameters: SCAN_DIV=4, REVEAL_DIV=16, BLINK_DIV=8.
- Reset: hold rst=0, then release with state IDLE and serial_done=1 → an_n=3F and revealed=0 indefinitely; no capture.
- Capture and reveal: state=1, serial "AB3Z57" (41423 35A3537), serial_done=1.
  - Required: within 16 cycles only an_n[0] pulses, with seg_n=~77=08.
  - revealed=1 about 97 cycles after capture.
  - Slot 3 shows seg_n=~5B=24.
- Odd flag and unsupported code:
  - Serial "OOOOO7" → slots 0–4 show seg_n=3F ('-').
  - In SHOW, slot 5 shows seg_n=78 with dp_n=0.
  - Serial "A00002" → dp_n stays 1.
- Blink: after SHOW, state=3 → anodes are scanned for 8 cycles, then an_n=3F for 8 cycles, repeating; back to state=2 → steady.
- Abort: state→0 at rev_cnt=3.
  - Next cycle: an_n=3F, revealed=0.
  - Then state=1 with a new serial → reveal restarts at char0 with the new value.
- Async reset: assert rst during SHOW between clock edges → outputs go to their reset values without waiting for a clock edge.
